// File: rtl/sdram_port_arbiter.sv
// Arbitrates the single Avalon-MM SDRAM master between the display line fetcher
// (burst reads, high priority) and the sprite blitter (single-word accesses).
module sdram_port_arbiter #(
    parameter int MAX_BURST    = 16,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        disp_req,
    input  logic [24:0] disp_addr,
    input  logic [4:0]  disp_len,
    output logic [31:0] disp_rdata,
    output logic        disp_rvalid,
    output logic        disp_done,
    input  logic        blt_read,
    input  logic        blt_write,
    input  logic [24:0] blt_addr,
    input  logic [31:0] blt_wdata,
    output logic [31:0] blt_rdata,
    output logic        blt_ack,
    output logic [24:0] sdram_address,
    output logic        sdram_read_n,
    output logic        sdram_write_n,
    output logic [3:0]  sdram_byteen_n,
    output logic [31:0] sdram_writedata,
    input  logic [31:0] sdram_readdata,
    input  logic        sdram_rvalid,
    input  logic        sdram_wait
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [2:0] {
        IDLE, D_ISSUE, D_DRAIN, B_READ, B_RWAIT, B_WRITE, D_DONE
    } state_t;

    state_t        state;
    logic [24:0]   base;
    logic [4:0]    len;
    logic [4:0]    issued;
    logic [4:0]    returned;
    logic [SW-1:0] starve;
    logic          blt_pend;
    logic [4:0]    clamped_len;
    logic          grant_disp;
    logic          grant_blt;

    // The acknowledged request is still held during the ack cycle; it must not re-win.
    assign blt_pend    = (blt_read | blt_write) & ~blt_ack;
    assign clamped_len = (disp_len > 5'(MAX_BURST)) ? 5'(MAX_BURST) : disp_len;

    always_comb begin
        grant_disp = 1'b0;
        grant_blt  = 1'b0;
        if (state == IDLE) begin
            if (disp_req && blt_pend) begin
                if (starve == SW'(STARVE_LIMIT)) grant_blt = 1'b1;
                else                             grant_disp = 1'b1;
            end else if (disp_req) begin
                grant_disp = 1'b1;
            end else if (blt_pend) begin
                grant_blt = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state           <= IDLE;
            base            <= '0;
            len             <= '0;
            issued          <= '0;
            returned        <= '0;
            starve          <= '0;
            sdram_address   <= '0;
            sdram_read_n    <= 1'b1;
            sdram_write_n   <= 1'b1;
            sdram_byteen_n  <= '1;
            sdram_writedata <= '0;
            disp_rdata      <= '0;
            disp_rvalid     <= 1'b0;
            disp_done       <= 1'b0;
            blt_rdata       <= '0;
            blt_ack         <= 1'b0;
        end else begin
            disp_rvalid <= 1'b0;
            disp_done   <= 1'b0;
            blt_ack     <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (grant_disp) begin
                        base     <= disp_addr;
                        len      <= clamped_len;
                        issued   <= '0;
                        returned <= '0;
                        if (blt_pend) starve <= starve + SW'(1);
                        if (clamped_len == '0) begin
                            disp_done <= 1'b1;
                            state     <= D_DONE;
                        end else begin
                            sdram_address  <= disp_addr;
                            sdram_read_n   <= 1'b0;
                            sdram_byteen_n <= '0;
                            state          <= D_ISSUE;
                        end
                    end else if (grant_blt) begin
                        starve         <= '0;
                        sdram_address  <= blt_addr;
                        sdram_byteen_n <= '0;
                        if (blt_read) begin
                            sdram_read_n <= 1'b0;
                            state        <= B_READ;
                        end else begin
                            sdram_write_n   <= 1'b0;
                            sdram_writedata <= blt_wdata;
                            state           <= B_WRITE;
                        end
                    end
                end
                D_ISSUE: begin
                    // Address advances only once the current word is accepted.
                    if (!sdram_wait) begin
                        issued <= issued + 5'd1;
                        if (issued + 5'd1 == len) begin
                            sdram_read_n   <= 1'b1;
                            sdram_byteen_n <= '1;
                            state          <= D_DRAIN;
                        end else begin
                            sdram_address <= base + 25'(issued) + 25'd1;
                        end
                    end
                end
                D_DRAIN: begin
                    if (returned == len) begin
                        disp_done <= 1'b1;
                        state     <= D_DONE;
                    end
                end
                D_DONE: state <= IDLE;
                B_READ: begin
                    if (!sdram_wait) begin
                        sdram_read_n   <= 1'b1;
                        sdram_byteen_n <= '1;
                        state          <= B_RWAIT;
                    end
                end
                B_RWAIT: begin
                    if (sdram_rvalid) begin
                        blt_rdata <= sdram_readdata;
                        blt_ack   <= 1'b1;
                        state     <= IDLE;
                    end
                end
                B_WRITE: begin
                    if (!sdram_wait) begin
                        sdram_write_n  <= 1'b1;
                        sdram_byteen_n <= '1;
                        blt_ack        <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // Display returns can overlap issue, so they are collected in both states.
            if ((state == D_ISSUE || state == D_DRAIN) && sdram_rvalid && returned < len) begin
                disp_rdata  <= sdram_readdata;
                disp_rvalid <= 1'b1;
                returned    <= returned + 5'd1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench for sdram_port_arbiter: SDRAM slave model, per-requester
// expectation queues and a negedge monitor that pops them as the DUT responds.
module tb_sdram_port_arbiter;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        disp_req = 1'b0;
    logic [24:0] disp_addr = '0;
    logic [4:0]  disp_len = '0;
    logic [31:0] disp_rdata;
    logic        disp_rvalid;
    logic        disp_done;
    logic        blt_read = 1'b0;
    logic        blt_write = 1'b0;
    logic [24:0] blt_addr = '0;
    logic [31:0] blt_wdata = '0;
    logic [31:0] blt_rdata;
    logic        blt_ack;
    logic [24:0] sdram_address;
    logic        sdram_read_n;
    logic        sdram_write_n;
    logic [3:0]  sdram_byteen_n;
    logic [31:0] sdram_writedata;
    logic [31:0] sdram_readdata = '0;
    logic        sdram_rvalid = 1'b0;
    logic        sdram_wait = 1'b0;

    always #5 Clk = ~Clk;

    sdram_port_arbiter #(.MAX_BURST(16), .STARVE_LIMIT(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .disp_req(disp_req), .disp_addr(disp_addr), .disp_len(disp_len),
        .disp_rdata(disp_rdata), .disp_rvalid(disp_rvalid), .disp_done(disp_done),
        .blt_read(blt_read), .blt_write(blt_write), .blt_addr(blt_addr),
        .blt_wdata(blt_wdata), .blt_rdata(blt_rdata), .blt_ack(blt_ack),
        .sdram_address(sdram_address), .sdram_read_n(sdram_read_n),
        .sdram_write_n(sdram_write_n), .sdram_byteen_n(sdram_byteen_n),
        .sdram_writedata(sdram_writedata), .sdram_readdata(sdram_readdata),
        .sdram_rvalid(sdram_rvalid), .sdram_wait(sdram_wait)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    typedef struct { bit is_done; logic [31:0] data; } dexp_t;
    typedef struct { bit is_read; logic [31:0] data; } bexp_t;
    typedef struct { logic [24:0] addr; logic [31:0] data; } wexp_t;
    typedef struct { int due; logic [31:0] data; } ret_t;

    dexp_t disp_q[$];
    bexp_t blt_q[$];
    wexp_t wr_q[$];
    ret_t  ret_q[$];
    logic [31:0] ref_mem [bit [24:0]];
    logic [31:0] ram [bit [24:0]];

    // slave model knobs and observation counters
    int          lat_min = 1, lat_max = 1;
    bit          rand_wait = 0;
    logic [24:0] hold_addr = '0;
    int          hold_n = 0, hold_cnt = 0, hold_seen = 0;
    int          rd_low = 0, wr_low = 0, rv_cnt = 0, last_due = 0;
    int          last_rv_cyc = -10, wr_seen = 0, wr_acks = 0;
    int          disp_rv_seen = 0, blt_ack_seen = 0;
    bit          w;
    int          lat, due;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        failures++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] base_word(input logic [24:0] a);
        return ({7'd0, a} * 32'h9E3779B1) ^ 32'hC3A5_0F0F;
    endfunction

    function automatic logic [31:0] ref_rd(input logic [24:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return base_word(a);
    endfunction

    function automatic logic [31:0] ram_rd(input logic [24:0] a);
        if (ram.exists(a)) return ram[a];
        return base_word(a);
    endfunction

    // Monitor + SDRAM slave; everything sampled away from the active edge.
    always @(negedge Clk) begin
        cyc++;
        if (disp_rvalid) begin
            disp_rv_seen++;
            if (disp_q.size() == 0 || disp_q[0].is_done) begin
                flag($sformatf("disp_rvalid unexpected data=%h", disp_rdata));
            end else begin
                chk("disp_rdata", disp_rdata, disp_q[0].data);
                disp_q.delete(0);
            end
            last_rv_cyc = cyc;
        end
        if (disp_done) begin
            if (disp_q.size() == 0 || !disp_q[0].is_done) begin
                flag("disp_done unexpected");
            end else begin
                if (disp_q[0].data != 0) chk("done_after_last", 32'(cyc - last_rv_cyc), 1);
                else chk("done_len0_no_rvalid", 32'(disp_rvalid), 0);
                disp_q.delete(0);
            end
        end
        if (blt_ack) begin
            blt_ack_seen++;
            if (blt_q.size() == 0) begin
                flag("blt_ack unexpected");
            end else begin
                if (blt_q[0].is_read) begin
                    chk("blt_rdata", blt_rdata, blt_q[0].data);
                end else begin
                    chk("blt_write_before_ack", 32'(wr_seen), 32'(wr_acks + 1));
                    wr_acks++;
                end
                blt_q.delete(0);
            end
        end

        if (!sdram_read_n) rd_low++;
        if (!sdram_write_n) wr_low++;
        if ((!sdram_read_n || !sdram_write_n) && sdram_address == hold_addr) hold_seen++;

        w = 1'b0;
        if ((!sdram_read_n || !sdram_write_n) && sdram_address == hold_addr && hold_cnt < hold_n) begin
            w = 1'b1;
            hold_cnt++;
        end else if (rand_wait && $urandom_range(0, 3) == 0) begin
            w = 1'b1;
        end
        sdram_wait = w;

        if (!w && !sdram_read_n) begin
            chk("rd_byteen_n", 32'(sdram_byteen_n), 0);
            lat = $urandom_range(lat_min, lat_max);
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            ret_q.push_back('{due, ram_rd(sdram_address)});
        end
        if (!w && !sdram_write_n) begin
            chk("wr_byteen_n", 32'(sdram_byteen_n), 0);
            wr_seen++;
            if (wr_q.size() == 0) begin
                flag($sformatf("sdram write unexpected addr=%h", sdram_address));
            end else begin
                chk("wr_addr", 32'(sdram_address), 32'(wr_q[0].addr));
                chk("wr_data", sdram_writedata, wr_q[0].data);
                wr_q.delete(0);
            end
            ram[sdram_address] = sdram_writedata;
        end

        if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
            sdram_rvalid   = 1'b1;
            sdram_readdata = ret_q[0].data;
            ret_q.delete(0);
            rv_cnt++;
        end else begin
            sdram_rvalid   = 1'b0;
            sdram_readdata = $urandom;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic wait_disp_done();
        for (int i = 0; i < 3000; i++) begin
            @(posedge Clk);
            #1;
            if (disp_done) return;
        end
        flag("timeout waiting for disp_done");
    endtask

    task automatic wait_blt_ack();
        for (int i = 0; i < 3000; i++) begin
            @(posedge Clk);
            #1;
            if (blt_ack) return;
        end
        flag("timeout waiting for blt_ack");
    endtask

    task automatic push_burst(input logic [24:0] a, input logic [4:0] l);
        int n;
        logic [24:0] x;
        n = (l > 5'd16) ? 16 : int'(l);
        for (int i = 0; i < n; i++) begin
            x = a + 25'(i);
            disp_q.push_back('{1'b0, ref_rd(x)});
        end
        disp_q.push_back('{1'b1, 32'(n)});
    endtask

    // Holds disp_req across n back-to-back bursts of the same request.
    task automatic disp_burst(input logic [24:0] a, input logic [4:0] l, input int n);
        disp_addr = a;
        disp_len  = l;
        disp_req  = 1'b1;
        for (int k = 0; k < n; k++) begin
            push_burst(a, l);
            wait_disp_done();
        end
        disp_req = 1'b0;
    endtask

    task automatic blt_op(input bit rd, input bit wr, input logic [24:0] a, input logic [31:0] d);
        blt_addr  = a;
        blt_wdata = d;
        blt_read  = rd;
        blt_write = wr;
        if (rd) begin
            blt_q.push_back('{1'b1, ref_rd(a)});
        end else begin
            blt_q.push_back('{1'b0, 32'h0});
            wr_q.push_back('{a, d});
            ref_mem[a] = d;
        end
        wait_blt_ack();
        blt_read  = 1'b0;
        blt_write = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_read_n"},    32'(sdram_read_n), 1);
        chk({tag, "_write_n"},   32'(sdram_write_n), 1);
        chk({tag, "_byteen_n"},  32'(sdram_byteen_n), 32'hF);
        chk({tag, "_address"},   32'(sdram_address), 0);
        chk({tag, "_writedata"}, sdram_writedata, 0);
        chk({tag, "_pulses"},    32'({disp_rvalid, disp_done, blt_ack}), 0);
        chk({tag, "_disp_rdata"}, disp_rdata, 0);
        chk({tag, "_blt_rdata"},  blt_rdata, 0);
    endtask

    int          starve_n;
    bit          starve_seen;
    logic [24:0] ra_d, ra_b;
    logic [4:0]  rl_d;
    int          rsel;

    initial begin
        idle(3);
        check_reset("rst");
        Reset = 1'b0;
        idle(2);

        // basic burst, fixed 3-cycle read latency
        lat_min = 3; lat_max = 3;
        rd_low = 0;
        disp_burst(25'h100, 5'd4, 1);
        chk("t1_read_cycles", 32'(rd_low), 4);
        idle(3);

        // waitrequest stretches the second word
        hold_addr = 25'h101; hold_n = 2; hold_cnt = 0; hold_seen = 0; rd_low = 0;
        disp_burst(25'h100, 5'd4, 1);
        chk("t2_addr101_cycles", 32'(hold_seen), 3);
        chk("t2_read_cycles", 32'(rd_low), 6);
        hold_n = 0;
        idle(3);

        // blitter write with one wait cycle
        hold_addr = 25'h2000; hold_n = 1; hold_cnt = 0; wr_low = 0;
        blt_op(1'b0, 1'b1, 25'h2000, 32'hDEADBEEF);
        idle(3);
        chk("t3_write_cycles", 32'(wr_low), 2);
        hold_n = 0;

        // read wins when both blitter strobes are high
        blt_op(1'b1, 1'b1, 25'h2000, 32'h12345678);
        idle(3);

        // starvation guard under continuous display traffic
        lat_min = 1; lat_max = 2;
        fork
            disp_burst(25'h300, 5'd2, 6);
            begin
                wait_disp_done();
                fork
                    blt_op(1'b1, 1'b0, 25'h0900000, 32'h0);
                    begin
                        starve_n = 0;
                        starve_seen = 0;
                        for (int i = 0; i < 3000 && !starve_seen; i++) begin
                            @(posedge Clk);
                            #1;
                            if (disp_done) starve_n++;
                            if (!sdram_read_n && sdram_address == 25'h0900000) starve_seen = 1;
                        end
                        chk("starve_bursts_before_blt", 32'(starve_n), 4);
                    end
                join
            end
        join
        idle(3);

        // zero length, wrap-around and clamp
        rd_low = 0;
        disp_burst(25'h40, 5'd0, 1);
        chk("t5_len0_read_cycles", 32'(rd_low), 0);
        disp_burst(25'h1FFFFFF, 5'd2, 1);
        rd_low = 0;
        disp_burst(25'h800, 5'd20, 1);
        chk("clamp_read_cycles", 32'(rd_low), 16);
        idle(3);

        // reset while two reads are still outstanding
        lat_min = 5; lat_max = 5;
        rv_cnt = 0;
        disp_addr = 25'h400; disp_len = 5'd4; disp_req = 1'b1;
        push_burst(25'h400, 5'd4);
        for (int i = 0; i < 200 && rv_cnt < 2; i++) begin
            @(posedge Clk);
            #1;
        end
        chk("t6_returns_before_reset", 32'(rv_cnt), 2);
        Reset = 1'b1;
        disp_req = 1'b0;
        disp_q.delete();
        #1;
        check_reset("midrst");
        disp_rv_seen = 0;
        blt_ack_seen = 0;
        idle(3);
        Reset = 1'b0;
        for (int i = 0; i < 100 && ret_q.size() > 0; i++) idle(1);
        idle(3);
        chk("t6_late_disp_rvalid", 32'(disp_rv_seen), 0);
        chk("t6_late_blt_ack", 32'(blt_ack_seen), 0);
        lat_min = 1; lat_max = 4;
        disp_burst(25'h500, 5'd3, 1);
        blt_op(1'b1, 1'b0, 25'h0900010, 32'h0);
        idle(3);

        // randomized concurrent traffic
        rand_wait = 1;
        fork
            for (int k = 0; k < 30; k++) begin
                if (k % 7 == 3) ra_d = 25'h1FFFFF0 + 25'($urandom_range(0, 15));
                else            ra_d = 25'($urandom_range(0, 32'h000FFFFF));
                rl_d = 5'($urandom_range(0, 20));
                disp_burst(ra_d, rl_d, 1);
                idle($urandom_range(0, 3));
            end
            for (int k = 0; k < 40; k++) begin
                ra_b = 25'h0800000 | 25'($urandom_range(0, 63));
                rsel = $urandom_range(0, 2);
                blt_op(rsel != 1, rsel != 0, ra_b, $urandom);
                idle($urandom_range(0, 4));
            end
        join
        rand_wait = 0;
        idle(30);
        chk("end_disp_q_empty", 32'(disp_q.size()), 0);
        chk("end_blt_q_empty", 32'(blt_q.size()), 0);
        chk("end_wr_q_empty", 32'(wr_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global timeout");
        $fatal(1, "global timeout");
    end

endmodule
